cpu_run_ctrl: RTL and testbench

- Sequencer for the single-cycle rv32is core's clock.
- Generates the gated CPU clock pulse `cpu_clk`, the CPU reset `cpu_rst`, and run/halt/single-step control.
- Counts retired instructions and halts on an optional PC breakpoint.
- Sits between the board clock/buttons and the core's `clock`/`reset` inputs.
- Button inputs arrive as debounced one-cycle pulses.

---
 rtl/cpu_ctrl_pkg.sv | 14 +
 rtl/cpu_run_ctrl_if.sv | 31 +++
 rtl/cpu_run_ctrl_run_divider.sv | 41 ++++
 rtl/cpu_run_ctrl.sv | 139 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run controller: state encoding and the
// reset vector the core starts from after cpu_rst is released.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_HALT = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } state_e;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

endpackage : cpu_ctrl_pkg

// File: rtl/cpu_run_ctrl_if.sv
// Control/status bundle between the board-side controller logic and the
// run controller: button pulses, divider ratio, breakpoint and core status.
interface cpu_run_ctrl_if #(
  parameter int DIV_W = 24,
  parameter int CNT_W = 32
) ();

  logic             run_req;
  logic             halt_req;
  logic             step_req;
  logic [DIV_W-1:0] div_ratio;
  logic [31:0]      cpu_pc;
  logic [31:0]      brk_addr;
  logic             brk_valid;
  logic             cpu_clk;
  logic             cpu_rst;
  logic [1:0]       state;
  logic [CNT_W-1:0] instr_cnt;
  logic             brk_hit;

  modport master (
    output run_req, halt_req, step_req, div_ratio, cpu_pc, brk_addr, brk_valid,
    input  cpu_clk, cpu_rst, state, instr_cnt, brk_hit
  );

  modport slave (
    input  run_req, halt_req, step_req, div_ratio, cpu_pc, brk_addr, brk_valid,
    output cpu_clk, cpu_rst, state, instr_cnt, brk_hit
  );

endinterface : cpu_run_ctrl_if

// File: rtl/cpu_run_ctrl_run_divider.sv
// Run-mode divider: counts 0..R with R = max(ratio,1) and flags the compare
// cycle. A ratio change is seen at the next compare; the count only returns
// to 0 on a terminal count or a clear.
module run_divider #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [DIV_W-1:0] ratio,
  output logic             tc
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] r_eff;

  assign r_eff = (ratio == '0) ? DIV_W'(1) : ratio;
  assign tc    = en && (cnt_q == r_eff);

  // Next count: clear wins, otherwise advance or wrap at terminal count.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // through this block can leave it unassigned and infer a latch.
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + DIV_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before the edge, independent of block evaluation order.
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule : run_divider

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer for the single-cycle core's clock.
// Produces the gated cpu_clk pulse train and cpu_rst, counts issued pulses
// and optionally halts on a PC breakpoint.
// Build option: define CPU_RUN_CTRL_BRKPT_EN to enable the breakpoint;
// without it brk_addr/brk_valid are ignored and brk_hit stays 0.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DIV_W      = 24,
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 32
) (
  input logic           clk,
  input logic           reset,
  cpu_run_ctrl_if.slave bus
);

  localparam int INIT_W = $clog2(RST_CYCLES + 1);

  state_e            state_q, state_d;
  logic              cpu_clk_q, cpu_clk_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic              first_q, first_d;     // next RUN pulse is the first one
  logic              brk_hit_q, brk_hit_d;
  logic              div_tc;
  logic              brk_fire;

  run_divider #(.DIV_W(DIV_W)) u_run_divider (
    .clk   (clk),
    .reset (reset),
    .clear (state_q != ST_RUN),
    .en    (state_q == ST_RUN),
    .ratio (bus.div_ratio),
    .tc    (div_tc)
  );

`ifdef CPU_RUN_CTRL_BRKPT_EN
  // The first pulse after entering RUN is exempt so RUN can resume from the
  // PC it stopped on.
  assign brk_fire    = div_tc && bus.brk_valid && (bus.cpu_pc == bus.brk_addr) && !first_q;
  assign bus.brk_hit = brk_hit_q;
`else
  assign brk_fire    = 1'b0;
  assign bus.brk_hit = 1'b0;
  logic unused_brk;
  assign unused_brk = ^{bus.cpu_pc, bus.brk_addr, bus.brk_valid, brk_hit_q};
`endif

  // Next state, pulse shaping and counters.
  always_comb begin
    state_d     = state_q;
    cpu_clk_d   = 1'b0;          // pulses are one cycle wide unless re-asserted
    cpu_rst_d   = cpu_rst_q;
    instr_cnt_d = instr_cnt_q;
    init_cnt_d  = init_cnt_q;
    first_d     = first_q;
    brk_hit_d   = brk_hit_q;

    unique case (state_q)
      ST_INIT: begin
        // Toggle cpu_clk while cpu_rst is held so the core's negedge PC
        // register captures its reset; these edges are not instructions.
        if (init_cnt_q == INIT_W'(RST_CYCLES)) begin
          cpu_rst_d = 1'b0;
          state_d   = ST_HALT;
        end else begin
          cpu_clk_d  = ~cpu_clk_q;
          init_cnt_d = init_cnt_q + INIT_W'(1);
        end
      end

      ST_HALT: begin
        if (bus.halt_req) begin
          state_d = ST_HALT;
        end else if (bus.step_req) begin
          state_d   = ST_STEP;
          brk_hit_d = 1'b0;
        end else if (bus.run_req) begin
          state_d   = ST_RUN;
          first_d   = 1'b1;
          brk_hit_d = 1'b0;
        end
      end

      ST_STEP: begin
        // cpu_clk high means the pulse was issued; otherwise this is the
        // entry cycle, where halt_req may still cancel it.
        if (cpu_clk_q || bus.halt_req) begin
          state_d = ST_HALT;
        end else begin
          cpu_clk_d   = 1'b1;
          instr_cnt_d = instr_cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (brk_fire) brk_hit_d = 1'b1;
        if (bus.halt_req || brk_fire) begin
          state_d = ST_HALT;
        end else if (div_tc) begin
          cpu_clk_d   = 1'b1;
          instr_cnt_d = instr_cnt_q + CNT_W'(1);
          first_d     = 1'b0;
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

  // State and output registers; reset drops any pulse in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      cpu_clk_q   <= 1'b0;
      cpu_rst_q   <= 1'b1;
      instr_cnt_q <= '0;
      init_cnt_q  <= '0;
      first_q     <= 1'b0;
      brk_hit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpu_clk_q   <= cpu_clk_d;
      cpu_rst_q   <= cpu_rst_d;
      instr_cnt_q <= instr_cnt_d;
      init_cnt_q  <= init_cnt_d;
      first_q     <= first_d;
      brk_hit_q   <= brk_hit_d;
    end
  end

  assign bus.cpu_clk   = cpu_clk_q;
  assign bus.cpu_rst   = cpu_rst_q;
  assign bus.state     = state_q;
  assign bus.instr_cnt = instr_cnt_q;

endmodule : cpu_run_ctrl

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios with literal expectations plus
// randomized request traffic, all compared every cycle against a
// behavioural model of the run controller.
module tb_cpu_run_ctrl;
  import cpu_ctrl_pkg::*;

  localparam int DIV_W      = 4;
  localparam int RST_CYCLES = 4;
  localparam int CNT_W      = 4;
`ifdef CPU_RUN_CTRL_BRKPT_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

  cpu_run_ctrl #(.DIV_W(DIV_W), .RST_CYCLES(RST_CYCLES), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Core PC stand-in: held at the reset vector during cpu_rst, +4 per pulse.
  logic [31:0] pc_env = RESET_VECTOR;
  always @(posedge clk) begin
    if (bus.cpu_rst)      pc_env <= RESET_VECTOR;
    else if (bus.cpu_clk) pc_env <= pc_env + 32'd4;
  end
  assign bus.cpu_pc = pc_env;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int st;      // 0 INIT, 1 HALT, 2 RUN, 3 STEP
    bit clk;
    bit rst;
    bit brk;
    bit first;   // no pulse yet since RUN was entered
    int cnt;     // pulses since reset, unbounded
    int init;    // INIT cycles elapsed
    int phase;   // cycles since RUN entry / last compare
  } model_t;

  model_t m;

  function automatic model_t next_model(model_t c, bit rst_in, bit hq, bit sq, bit rq,
                                        int ratio, bit bvalid, logic [31:0] pc,
                                        logic [31:0] baddr);
    model_t n = c;
    int r;
    bit fire, bfire;
    if (rst_in) begin
      n.st = 0; n.rst = 1; n.clk = 0; n.brk = 0; n.first = 0;
      n.cnt = 0; n.init = 0; n.phase = 0;
      return n;
    end
    n.clk = 0;
    case (c.st)
      0: begin
        if (c.init == RST_CYCLES) begin n.rst = 0; n.st = 1; end
        else begin n.clk = !c.clk; n.init = c.init + 1; end
      end
      1: begin
        if (hq) n.st = 1;
        else if (sq) begin n.st = 3; n.brk = 0; end
        else if (rq) begin n.st = 2; n.brk = 0; n.first = 1; n.phase = 0; end
      end
      3: begin
        if (c.clk || hq) n.st = 1;
        else begin n.clk = 1; n.cnt = c.cnt + 1; end
      end
      default: begin
        r = (ratio == 0) ? 1 : ratio;
        fire = (c.phase == r);
        n.phase = fire ? 0 : (c.phase + 1) % (1 << DIV_W);
        bfire = BRK_EN && fire && bvalid && (pc == baddr) && !c.first;
        if (bfire) n.brk = 1;
        if (hq || bfire) n.st = 1;
        else if (fire) begin n.clk = 1; n.cnt = c.cnt + 1; n.first = 0; end
      end
    endcase
    return n;
  endfunction

  always @(posedge clk)
    m <= next_model(m, reset, bus.halt_req, bus.step_req, bus.run_req, int'(bus.div_ratio),
                    bus.brk_valid, bus.cpu_pc, bus.brk_addr);

  // Single compare process: every cycle, DUT vs model.
  bit armed = 1'b0;
  always @(negedge clk) begin
    if (armed) begin
      check("state",     bus.state,     m.st);
      check("cpu_clk",   bus.cpu_clk,   m.clk);
      check("cpu_rst",   bus.cpu_rst,   m.rst);
      check("instr_cnt", bus.instr_cnt, m.cnt % (1 << CNT_W));
      check("brk_hit",   bus.brk_hit,   m.brk);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit h, input bit s, input bit r);
    bus.halt_req = h; bus.step_req = s; bus.run_req = r;
    tick();
    bus.halt_req = 0; bus.step_req = 0; bus.run_req = 0;
  endtask

  task automatic run_cycles(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      tick();
      if (bus.cpu_clk) pulses++;
    end
  endtask

  task automatic init_seq(input string tag);
    int rst_hi = 0;
    int tog    = 0;
    logic prev;
    reset = 0;
    prev  = bus.cpu_clk;
    repeat (RST_CYCLES + 4) begin
      tick();
      if (bus.cpu_rst) rst_hi++;
      if (bus.cpu_clk !== prev) tog++;
      prev = bus.cpu_clk;
    end
    check({tag, "_rst_cycles"}, rst_hi, 4);
    check({tag, "_toggles"},    tog,    4);
    check({tag, "_state"},      bus.state, 1);
    check({tag, "_cnt"},        bus.instr_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, tot, cyc, np, last, iv, first_iv, last_iv;
    logic [31:0] pc_at;
    bus.run_req = 0; bus.halt_req = 0; bus.step_req = 0;
    bus.div_ratio = '0; bus.brk_addr = '0; bus.brk_valid = 0;

    // Reset values and INIT sequence.
    reset = 1;
    repeat (3) tick();
    armed = 1;
    check("rst_state",   bus.state,     0);
    check("rst_cpu_rst", bus.cpu_rst,   1);
    check("rst_cpu_clk", bus.cpu_clk,   0);
    check("rst_cnt",     bus.instr_cnt, 0);
    init_seq("init");

    // Single steps spaced five cycles apart.
    tot = 0;
    for (int i = 0; i < 3; i++) begin
      req(0, 1, 0);
      run_cycles(4, p);
      tot += p;
      check("step_state", bus.state, 1);
    end
    check("step_pulses", tot, 3);
    check("step_cnt",    bus.instr_cnt, 3);

    // Run with ratio 3 (period 4), then ratio 0 (period 2), halt after 10.
    bus.div_ratio = 4'd3;
    req(0, 0, 1);
    np = 0; last = -1; cyc = 0; first_iv = 0; last_iv = 0;
    while (np < 10 && cyc < 200) begin
      tick();
      cyc++;
      if (bus.cpu_clk) begin
        np++;
        if (last >= 0) begin
          iv = cyc - last;
          if (np == 2) first_iv = iv;
          last_iv = iv;
        end
        last = cyc;
        if (np == 4) bus.div_ratio = '0;
      end
    end
    check("run_pulses",   np, 10);
    check("run_period_3", first_iv, 4);
    check("run_period_0", last_iv, 2);
    req(1, 0, 0);
    run_cycles(10, p);
    check("halt_no_pulse", p, 0);
    check("halt_cnt",      bus.instr_cnt, 13);
    check("halt_state",    bus.state, 1);

    // Breakpoint at 0x0C from a fresh reset.
    reset = 1;
    repeat (2) tick();
    init_seq("bp_init");
    bus.brk_addr = 32'h0C; bus.brk_valid = 1; bus.div_ratio = 4'd1;
    req(0, 0, 1);
    np = 0; cyc = 0;
    while (bus.state != 2'd1 && cyc < 40) begin
      tick();
      cyc++;
      if (bus.cpu_clk) np++;
    end
    if (BRK_EN) begin
      check("bp_halted",  bus.state, 1);
      check("bp_pulses",  np, 3);
      check("bp_pc",      bus.cpu_pc, 32'h0C);
      check("bp_hit",     bus.brk_hit, 1);
      req(0, 0, 1);
      check("bp_cleared", bus.brk_hit, 0);
      cyc = 0;
      while (!bus.cpu_clk && cyc < 10) begin tick(); cyc++; end
      pc_at = bus.cpu_pc;
      check("bp_resume_pulse", bus.cpu_clk, 1);
      check("bp_resume_pc",    pc_at, 32'h0C);
    end else begin
      check("bp_ignored_state", bus.state, 2);
      check("bp_ignored_hit",   bus.brk_hit, 0);
      check("bp_ignored_runs",  np >= 4, 1);
    end
    req(1, 0, 0);
    bus.brk_valid = 0;
    tick();

    // Priority: halt beats everything; step beats run.
    req(1, 1, 1);
    run_cycles(4, p);
    check("prio_all_pulses", p, 0);
    check("prio_all_state",  bus.state, 1);
    req(0, 1, 1);
    check("prio_step_state", bus.state, 3);
    run_cycles(4, p);
    check("prio_step_pulses", p, 1);
    check("prio_step_end",    bus.state, 1);

    // Reset in the middle of RUN, then 17 steps wrap the 4-bit counter.
    bus.div_ratio = 4'd2;
    req(0, 0, 1);
    run_cycles(6, p);
    reset = 1;
    tick();
    check("midrst_state",   bus.state, 0);
    check("midrst_cpu_clk", bus.cpu_clk, 0);
    tick();
    init_seq("midrst");
    for (int i = 0; i < 17; i++) begin
      req(0, 1, 0);
      run_cycles(3, p);
    end
    check("wrap_cnt",   bus.instr_cnt, 1);
    check("wrap_state", bus.state, 1);

    // Randomized traffic; the compare process does the checking.
    for (int i = 0; i < 2000; i++) begin
      bus.halt_req = ($urandom_range(0, 23) == 0);
      bus.step_req = ($urandom_range(0, 9) == 0);
      bus.run_req  = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 19) == 0) bus.div_ratio = DIV_W'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)  bus.brk_valid = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) bus.brk_addr = 32'($urandom_range(0, 7) * 4);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    bus.halt_req = 0; bus.step_req = 0; bus.run_req = 0;
    reset = 0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_cpu_run_ctrl
